// File: rtl/mux4_1_rr_pkg.sv
// Shared definitions for the 4:1 round-robin mux and its matching 1:4 demux.
package mux_pkg;
  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux4_1_rr_if.sv
// Bundle of the four input streams and the merged output stream.
interface mux4_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic [CH_NUM*WIDTH-1:0] in_data;
  logic [CH_NUM-1:0]       in_valid;
  logic [CH_NUM-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  sel_t                    out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux4_1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, modulo 4.
module rr_arbiter4
  import mux_pkg::*;
(
  input  logic [CH_NUM-1:0] req_i,
  input  sel_t              ptr_i,
  output logic [CH_NUM-1:0] grant_o,
  output sel_t              gidx_o,
  output logic              any_o
);

  sel_t idx;

  // Scanning from the farthest offset down lets the nearest requester win last.
  always_comb begin
    grant_o = '0;
    gidx_o  = '0;
    idx     = '0;
    any_o   = |req_i;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      idx = ptr_i + sel_t'(k);
      if (req_i[idx]) begin
        gidx_o = idx;
      end
    end
    grant_o[gidx_o] = any_o;
  end

endmodule

// File: rtl/mux4_1_rr.sv
// Four-channel round-robin stream merger with a registered output word and channel code.
module mux4_1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic  clk,
  input  logic  rst_n,
  mux4_if.slave bus
);

  logic [CH_NUM-1:0] grant;
  sel_t              gidx;
  logic              anyReq;
  logic              space;
  logic              load;

  logic [WIDTH-1:0]  outData_q, outData_d;
  sel_t              outSel_q, outSel_d;
  logic              outValid_q, outValid_d;
  sel_t              ptr_q, ptr_d;

  rr_arbiter4 u_arb (
    .req_i   (bus.in_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .gidx_o  (gidx),
    .any_o   (anyReq)
  );

  // rst_n gates load so in_ready falls immediately when reset is asserted.
  assign space = ~outValid_q | bus.out_ready;
  assign load  = space & anyReq & rst_n;

  assign bus.in_ready  = grant & {CH_NUM{load}};
  assign bus.out_data  = outData_q;
  assign bus.out_sel   = outSel_q;
  assign bus.out_valid = outValid_q;

  always_comb begin
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
    if (load) begin
      outData_d  = bus.in_data[gidx*WIDTH +: WIDTH];
      outSel_d   = gidx;
      outValid_d = 1'b1;
      ptr_d      = gidx + sel_t'(1);
    end else if (space) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q  <= '0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux4_1_rr.sv
// Directed and randomized checks of mux4_1_rr against a queue-free behavioural model.
module tb_mux4_1_rr;
  import mux_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux4_if #(.WIDTH(WIDTH)) bus ();

  mux4_1_rr #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what out_* should show after the most recent edge.
  int mPtr;
  bit mValid;
  int mData;
  int mSel;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPtr   = 0;
    mValid = 0;
    mData  = 0;
    mSel   = 0;
  endtask

  // One cycle: check last edge's result, drive new inputs, check in_ready, predict next edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [4*WIDTH-1:0] d, input logic ordy);
    int g;
    bit space;
    bit load;
    logic [3:0] expRdy;
    @(negedge clk);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("out_data", 32'(bus.out_data), mData);
      checkOutput("out_sel", 32'(bus.out_sel), mSel);
    end
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    space = !mValid || ordy;
    g = -1;
    for (int o = 0; o < 4; o++) begin
      int c;
      c = (mPtr + o) % 4;
      if (g < 0 && v[c]) g = c;
    end
    load = space && (g >= 0) && (rst_n === 1'b1);
    expRdy = load ? 4'(1 << g) : 4'b0000;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(expRdy));
    if (load) begin
      mData  = int'(d[g*WIDTH +: WIDTH]);
      mSel   = g;
      mValid = 1;
      mPtr   = (g + 1) % 4;
    end else if (space) begin
      mValid = 0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 4'b0000;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [4*WIDTH-1:0] FAIR_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [4*WIDTH-1:0] BP_DATA   = {8'h3D, 8'h5C, 8'h1B, 8'h0A};

  initial begin
    modelReset();
    bus.in_valid  = 4'b1111;
    bus.in_data   = FAIR_DATA;
    bus.out_ready = 1'b0;

    // Reset with every channel requesting.
    #12;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("rst_out_sel", 32'(bus.out_sel), 32'h0);
    @(negedge clk);
    bus.in_valid = 4'b0000;
    rst_n = 1'b1;

    // Fairness: all requesting, no back-pressure.
    for (int i = 0; i < 6; i++) applyStimulus(4'b1111, FAIR_DATA, 1'b1);
    applyStimulus(4'b0000, FAIR_DATA, 1'b1);

    // Skip and wrap between ch1 and ch3.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'b1010, FAIR_DATA, 1'b1);

    // Back-pressure with ch2 holding 5C, then consume with a simultaneous load.
    doReset();
    applyStimulus(4'b0000, BP_DATA, 1'b1);
    applyStimulus(4'b0100, BP_DATA, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, BP_DATA, 1'b0);
    checkOutput("bp_out_data", 32'(bus.out_data), 32'h5C);
    checkOutput("bp_out_sel", 32'(bus.out_sel), 32'h2);
    applyStimulus(4'b1111, BP_DATA, 1'b1);
    applyStimulus(4'b0000, BP_DATA, 1'b1);

    // Drain: a single word appears for exactly one cycle.
    doReset();
    applyStimulus(4'b0001, FAIR_DATA, 1'b1);
    applyStimulus(4'b0000, FAIR_DATA, 1'b1);
    applyStimulus(4'b0000, FAIR_DATA, 1'b1);
    applyStimulus(4'b0000, FAIR_DATA, 1'b1);

    // Reset asserted while a word is held under back-pressure.
    applyStimulus(4'b0010, FAIR_DATA, 1'b0);
    applyStimulus(4'b1111, FAIR_DATA, 1'b0);
    @(negedge clk);
    checkOutput("mid_held_valid", 32'(bus.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    modelReset();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, FAIR_DATA, 1'b1);
    applyStimulus(4'b0000, FAIR_DATA, 1'b1);

    // Randomized traffic with occasional back-pressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 32'($urandom),
                    ($urandom_range(0, 3) != 0));
    end
    applyStimulus(4'b0000, FAIR_DATA, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_1_rr.md
# mux4_1_rr

Four-channel round-robin multiplexer with a registered output: it merges four valid/ready input streams onto one output stream. Each output word carries a 2-bit channel code that the downstream 1:4 demux uses as its select. Arbitration is fair among requesting channels, and throughput is one word per cycle when the output is not back-pressured.

## Interface
Parameters:
- WIDTH, 8, data width per channel.

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-low):
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  4  channel i has a word to transfer.
- in_ready  output  4  one-hot or zero; channel i's word is taken this cycle.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  2  registered channel index of out_data (00=ch0 … 11=ch3).
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accepts the word this cycle.

## Operation
- A transfer happens on a channel when valid and ready are both high at a clk edge. This applies to each in_* channel and to the out_* side.
- space = ~out_valid | out_ready.
- load = space & |in_valid.
- Grant: the first channel with in_valid=1, searching upward from ptr modulo 4 (ptr, ptr+1, …, ptr+3).
- in_ready[g] = load for the granted channel g. All other in_ready bits are 0. in_ready is combinational from in_valid, out_valid, out_ready and ptr.
- On load:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod 4. Wrap 3→0 is natural 2-bit overflow.
- On space with no in_valid: out_valid <= 0. out_data and out_sel keep their old values (don't-care).
- On out_valid & ~out_ready:
  - All output registers hold.
  - in_ready = 0.
  - ptr holds.
- A channel's in_data must stay stable while in_valid=1 and in_ready=0. The block does not check this.
- ptr changes only on load. A channel that keeps requesting is served at least once every 4 loads.
- State: out_data, out_sel, out_valid, ptr[1:0]. No FSM beyond these registers.

## Timing
- Reset (async assert, sync release expected): out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0.
- Latency: a word accepted at edge N appears on out_* immediately after edge N. It is visible for the cycle N→N+1.
- Throughput: with out_ready held at 1 and any in_valid present, one transfer per cycle.
- Simultaneous consume and load: out_valid stays 1 and the new word replaces the old at the same edge. There is no bubble.
- Reset asserted mid-stream:
  - The held output word is discarded.
  - ptr returns to 0.
  - in_ready drops to 0 combinationally with rst_n low.
- No combinational path from in_valid to out_*. The only combinational paths are in_valid/out_ready/out_valid → in_ready.

## Structure
- Shared package mux_pkg:
  - CH_NUM=4.
  - SEL_W=2.
  - Type sel_t (logic [SEL_W-1:0]), reused by the demux side for its select.
- Sub-module rr_arbiter4:
  - Combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: grant one-hot[3:0], gidx[1:0], any.
- The top-level holds the output register and ptr, and instantiates rr_arbiter4 once.

## Test plan
- Reset: rst_n=0 with all in_valid=1 → in_ready=0000, out_valid=0, out_data=0, out_sel=00. After release, first grant is ch0.
- Fairness: all four in_valid=1, out_ready=1, data ch i = 8'hA0+i → out_sel sequence 0,1,2,3,0,… and out_data A0,A1,A2,A3,A0 on consecutive cycles.
- Skip and wrap: only ch1 and ch3 valid, ptr=0 → grants 1,3,1,3. After ch3, ptr wraps to 0 and the next grant is ch1.
- Back-pressure: out_ready=0 for 3 cycles with ch2 word 8'h5C loaded → out_data=5C, out_sel=10, out_valid=1 stable. in_ready=0000 and ptr unchanged throughout. out_ready=1 then consumes, with a simultaneous new load.
- Drain: single word on ch0, then in_valid=0000, out_ready=1 → out_valid=1 for exactly one cycle, then 0.
- Reset mid-stream: assert rst_n low while out_valid=1 and out_ready=0 → out_valid=0 immediately. After release, grant restarts at ch0.
